// File: rtl/psum_accum_pipe.sv
// Pipelined NUM_IN-lane signed product adder tree feeding a packet accumulator.
// One result per packet over valid/ready; the whole pipe freezes on output stall.
module psum_accum_pipe #(
  parameter int NUM_IN = 8,
  parameter int IN_W   = 8,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 8,
  parameter bit SAT    = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_IN*IN_W-1:0] in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_data,
  output logic                   out_ovf,
  output logic [CNT_W-1:0]       out_cnt
);

  localparam int L  = $clog2(NUM_IN);
  localparam int TW = IN_W + L;
  localparam logic [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MINV = {1'b1, {(ACC_W-1){1'b0}}};

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Level k holds NUM_IN>>k partial sums, each IN_W+k bits wide.
  for (genvar k = 0; k <= L; k++) begin : lv
    localparam int N = NUM_IN >> k;
    localparam int W = IN_W + k;
    logic [N*W-1:0] d;
    logic           v;
    logic           l;
    if (k == 0) begin : g0
      assign d = in_data;
      assign v = in_valid;
      assign l = in_last;
    end else begin : gk
      localparam int PW = W - 1;
      logic [N*W-1:0] s;
      for (genvar j = 0; j < N; j++) begin : add
        logic [PW-1:0] a;
        logic [PW-1:0] b;
        assign a = lv[k-1].d[(2*j)*PW +: PW];
        assign b = lv[k-1].d[(2*j+1)*PW +: PW];
        assign s[j*W +: W] = {a[PW-1], a} + {b[PW-1], b};
      end
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          d <= '0;
          v <= 1'b0;
          l <= 1'b0;
        end else if (!stall) begin
          d <= s;
          v <= lv[k-1].v;
          l <= lv[k-1].l;
        end
      end
    end
  end

  logic [TW-1:0]    sum;
  logic             tv;
  logic             tl;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [CNT_W-1:0] cnt;
  logic             first;

  assign sum = lv[L].d;
  assign tv  = lv[L].v;
  assign tl  = lv[L].l;

  logic [ACC_W:0]   se;
  logic [ACC_W:0]   base;
  logic [ACC_W:0]   nx;
  logic             of;
  logic [ACC_W-1:0] res;
  logic             novf;
  logic [CNT_W-1:0] ncnt;

  always_comb begin
    se   = {{(ACC_W+1-TW){sum[TW-1]}}, sum};
    base = first ? '0 : {acc[ACC_W-1], acc};
    nx   = base + se;
    of   = nx[ACC_W] != nx[ACC_W-1];
    res  = nx[ACC_W-1:0];
    if (of && SAT) res = nx[ACC_W] ? MINV : MAXV;
    novf = (first ? 1'b0 : ovf) | of;
    ncnt = first ? CNT_W'(1) : cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
      first     <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_cnt   <= '0;
    end else if (!stall) begin
      out_valid <= tv && tl;
      if (tv) begin
        acc   <= res;
        ovf   <= novf;
        cnt   <= ncnt;
        first <= tl;
        if (tl) begin
          out_data <= res;
          out_ovf  <= novf;
          out_cnt  <= ncnt;
        end
      end
    end
  end

endmodule

// File: doc/psum_accum_pipe.md
Name: psum_accum_pipe

Overview:
- Parametrised, pipelined successor to the combinational 8-lane product adder tree.
- Sums NUM_IN signed products per beat through a registered adder tree, then accumulates successive beats into a packet partial sum.
- Emits one result per packet, marked by in_last, over a valid/ready handshake.
- Sits between the PE product lanes and the output/requant stage.

Parameters:
- NUM_IN, 8: number of product lanes; power of two, >=2.
- IN_W, 8: width of each signed product (two's complement).
- ACC_W, 16: accumulator/result width, signed; must be >= IN_W+log2(NUM_IN).
- CNT_W, 8: width of the beat counter reported with each result.
- SAT, 0: 1 = accumulator saturates at signed ACC_W limits; 0 = wraps.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  beat present.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  NUM_IN*IN_W  lane i at bits [i*IN_W +: IN_W], signed.
- in_last  in  1  beat is the final beat of a packet.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  ACC_W  signed packet sum.
- out_ovf  out  1  sticky: accumulator overflowed or saturated during this packet.
- out_cnt  out  CNT_W  number of beats in the packet (wraps mod 2^CNT_W).

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset values, applied when rst_n=0 at a clk edge: out_valid=0, out_data=0, out_ovf=0, out_cnt=0, all pipeline valid bits=0, accumulator=0, first-beat flag=1.
- Reset mid-packet discards the partial sum and all in-flight beats.
- Beat transfer: in_valid && in_ready. Result transfer: out_valid && out_ready.
- Stall: stall = out_valid && !out_ready.
  - in_ready = !stall.
  - While stalled, every pipeline register, the accumulator and all outputs hold.
  - No beat is lost or duplicated.
- Adder tree:
  - L = log2(NUM_IN) registered levels.
  - Level k adds pairs with operands sign-extended by one bit.
  - Final tree width is IN_W+L; no overflow is possible inside the tree.
  - in_last and a valid bit travel alongside each level.
- Accumulator stage, one cycle after the tree output is valid:
  - Tree sum is sign-extended to ACC_W+1.
  - If first-beat flag=1: acc = sum, cnt = 1, ovf cleared. Otherwise: acc = acc + sum, cnt = cnt + 1.
  - Overflow detection: the ACC_W+1 result falls outside the signed ACC_W range.
    - SAT=1: clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
    - SAT=0: keep the low ACC_W bits.
    - In both modes, set ovf.
  - If the beat carried last: load out_data, out_ovf and out_cnt from the new values, assert out_valid, set first-beat flag=1. Otherwise first-beat flag=0.
- out_valid deasserts on a result transfer unless a new last beat completes in the same cycle; back-to-back results are allowed.
- Latency: a last beat accepted at cycle t gives out_valid at t+L+1 when there is no stall. Throughput is 1 beat/cycle.
- Single-beat packets (in_last on the first beat) are legal.
- A beat with in_valid=0 changes nothing; bubbles inside a packet are allowed.
- Simultaneous result transfer and new last beat: the new result replaces the old one in the same edge, out_valid stays 1.

Test Plan:
- Defaults; one beat with all lanes 0x7F, in_last=1 -> 4 cycles later out_valid=1, out_data=1016 (0x03F8), out_cnt=1, out_ovf=0.
- Packet of 3 beats with all lanes 0x80 -> out_data=-3072 (0xF400), out_cnt=3, out_ovf=0; intermediate beats produce no out_valid.
- Continuous in_valid with out_ready=1:
  - Packet A: 2 beats, all lanes 0x01 -> out_data=16, out_cnt=2.
  - Packet B: 1 beat, all lanes 0xFF -> out_data=-8, out_cnt=1.
  - in_ready stays 1 throughout; results on consecutive-appropriate cycles.
- Backpressure: out_ready=0 when a result appears -> in_ready=0 next cycle; out_data and pipeline frozen for 5 cycles. Raise out_ready -> result accepted once, following packets correct, no beats lost.
- Overflow: 40 beats of all lanes 0x7F (sum 40640).
  - SAT=1 -> out_data=32767, out_ovf=1, out_cnt=40.
  - SAT=0 -> out_data=-24896 (0x9EC0), out_ovf=1.
  - Next normal packet -> out_ovf=0.
- Reset mid-packet: 2 beats of 0x7F, then rst_n=0 for 1 cycle, then one beat of 0x01 with last -> out_data=8, out_cnt=1; no stale result is ever emitted.
